// File: rtl/nn_pkg.sv
// Shared constants and types for the NN layer buffer readers.
// Holds the activation word format and the reader FSM encoding.
package nn_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int RELU2_DEPTH = 64;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2,
    RD_DONE  = 2'd3
  } reader_state_t;

  typedef logic signed [DATA_WIDTH-1:0] act_word_t;

endpackage

// File: rtl/nn_stream_reg.sv
// Single-entry valid/ready holding register carrying data, index and last flag.
// Shared by the layer buffer readers; o_free tells the owner a new word may be loaded.
module nn_stream_reg #(
  parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = nn_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_index,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_index,
  output logic                  o_last,
  output logic                  o_free
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_index;
  logic                  r_last;

  // Empty, or the held word leaves on this edge.
  assign o_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_index <= i_index;
      r_last  <= i_last;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_index = r_index;
  assign o_last  = r_last;

endmodule

// File: rtl/relu2_mem_reader.sv
// Streams the layer-2 ReLU activation buffer out over valid/ready, one word per handshake.
// Optional running argmax outputs are enabled with RELU2_READER_ARGMAX_EN.
module relu2_mem_reader #(
  parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = nn_pkg::ADDR_WIDTH,
  parameter int DEPTH      = nn_pkg::RELU2_DEPTH,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
`ifdef RELU2_READER_ARGMAX_EN
  ,
  output logic [DATA_WIDTH-1:0] max_data,
  output logic [ADDR_WIDTH-1:0] max_index
`endif
);

  import nn_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  reader_state_t         r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_busy;
  logic                  r_done;

  logic w_free;
  logic w_load;
  logic w_clear;
  logic w_is_last;
  logic w_hs;

  // Address comes only from the index register, never from the ready input.
  assign mem_read_addr = BASE + r_idx;
  assign w_is_last     = (r_idx == LAST_IDX);
  assign w_hs          = out_valid && out_ready;
  assign w_load        = (r_state == RD_READ) && w_free;
  assign w_clear       = (r_state == RD_DRAIN) && w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (start) begin
            r_state <= RD_READ;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RD_READ: begin
          if (w_free) begin
            if (w_is_last) r_state <= RD_DRAIN;
            else           r_idx   <= r_idx + 1'b1;
          end
        end
        RD_DRAIN: begin
          if (w_hs) begin
            r_state <= RD_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        RD_DONE: r_state <= RD_IDLE;
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  nn_stream_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_stream_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_clear(w_clear),
    .i_data (mem_read_data),
    .i_index(r_idx),
    .i_last (w_is_last),
    .i_ready(out_ready),
    .o_valid(out_valid),
    .o_data (out_data),
    .o_index(out_index),
    .o_last (out_last),
    .o_free (w_free)
  );

`ifdef RELU2_READER_ARGMAX_EN
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_max_data;
  logic [ADDR_WIDTH-1:0] r_max_index;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first     <= 1'b0;
      r_max_data  <= '0;
      r_max_index <= '0;
    end else if ((r_state == RD_IDLE) && start) begin
      r_first <= 1'b1;
    end else if (w_hs) begin
      r_first <= 1'b0;
      if (r_first || ($signed(out_data) > $signed(r_max_data))) begin
        r_max_data  <= out_data;
        r_max_index <= out_index;
      end
    end
  end

  assign max_data  = r_max_data;
  assign max_index = r_max_index;
`endif

endmodule

// File: tb/tb_relu2_mem_reader.sv
// Scoreboard bench for relu2_mem_reader: default instance plus a DEPTH=1/BASE_ADDR=5 instance.
// Argmax checks are compiled in when RELU2_READER_ARGMAX_EN is defined.
module tb_relu2_mem_reader;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] index;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, done, out_valid, out_ready, out_last;
  logic [15:0] mem_read_addr, out_index;
  logic [31:0] mem_read_data, out_data;

  logic        start1, busy1, done1, out_valid1, out_ready1, out_last1;
  logic [15:0] mem_read_addr1, out_index1;
  logic [31:0] mem_read_data1, out_data1;

`ifdef RELU2_READER_ARGMAX_EN
  logic [31:0] max_data, max_data1;
  logic [15:0] max_index, max_index1;
`endif

  logic [31:0] mem  [0:65535];
  logic [31:0] mem1 [0:65535];
  logic [31:0] expMem [0:63];

  exp_t expQ[$];
  exp_t expQ1[$];
  exp_t e, e1;

  int checks = 0;
  int failures = 0;
  int hsCount = 0, doneCount = 0, hsCount1 = 0, doneCount1 = 0;

  logic        prevValid, prevReady, prevLast;
  logic [31:0] prevData;
  logic [15:0] prevIndex;

  assign mem_read_data  = mem[mem_read_addr];
  assign mem_read_data1 = mem1[mem_read_addr1];

  relu2_mem_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
`ifdef RELU2_READER_ARGMAX_EN
    , .max_data(max_data), .max_index(max_index)
`endif
  );

  relu2_mem_reader #(.DEPTH(1), .BASE_ADDR(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_read_addr(mem_read_addr1), .mem_read_data(mem_read_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1)
`ifdef RELU2_READER_ARGMAX_EN
    , .max_data(max_data1), .max_index(max_index1)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor for the main instance: pops the scoreboard on each handshake and checks hold-stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prevData);
        checkOutput("hold_index", out_index, prevIndex);
        checkOutput("hold_last", out_last, prevLast);
      end
      if (out_valid && out_ready) begin
        hsCount++;
        if (expQ.size() == 0) begin
          checkOutput("sb_underflow", expQ.size(), 1);
        end else begin
          e = expQ.pop_front();
          checkOutput("word_data", out_data, e.data);
          checkOutput("word_index", out_index, e.index);
          checkOutput("word_last", out_last, e.last);
        end
      end
      if (done) doneCount++;
      prevValid = out_valid;
      prevReady = out_ready;
      prevData  = out_data;
      prevIndex = out_index;
      prevLast  = out_last;
    end
  end

  // Monitor for the single-word instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid1 && out_ready1) begin
        hsCount1++;
        if (expQ1.size() == 0) begin
          checkOutput("sb1_underflow", expQ1.size(), 1);
        end else begin
          e1 = expQ1.pop_front();
          checkOutput("word1_data", out_data1, e1.data);
          checkOutput("word1_index", out_index1, e1.index);
          checkOutput("word1_last", out_last1, e1.last);
        end
      end
      if (done1) doneCount1++;
    end
  end

  // mode 0: ready high; 1: ready 1,0,0,1; 2: restart attempt at index 20; 3: reset at index 30
  task automatic applyStimulus(input int mode);
    int cycles;
    bit restarted;
    bit aborted;
    for (int i = 0; i < 64; i++) expQ.push_back({expMem[i], 16'(i), (i == 63)});
    hsCount = 0;
    doneCount = 0;
    restarted = 0;
    aborted = 0;
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("busy_on_accept", busy, 1);
    checkOutput("valid_before_e1", out_valid, 0);
    cycles = 0;
    while (!done && !aborted && cycles < 400) begin
      @(posedge clk);
      cycles++;
      #1;
      start = 1'b0;
      if (cycles == 1) begin
        checkOutput("first_valid", out_valid, 1);
        checkOutput("first_index", out_index, 0);
      end
      if (mode == 1) out_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
      if (mode == 2 && !restarted && out_valid && out_index == 16'd20) begin
        start = 1'b1;
        restarted = 1;
      end
      if (mode == 3 && out_valid && out_index == 16'd30) begin
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", out_valid, 0);
        checkOutput("reset_async_busy", busy, 0);
        checkOutput("reset_async_index", out_index, 0);
        aborted = 1;
      end
    end
    if (aborted) begin
      expQ.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("no_done_after_reset", doneCount, 0);
      checkOutput("addr_in_reset", mem_read_addr, 0);
      rst_n = 1'b1;
    end else begin
      checkOutput("done_timeout", done, 1);
      if (mode == 0) checkOutput("done_latency", cycles, 65);
      checkOutput("busy_at_done", busy, 0);
      @(posedge clk); #1;
      checkOutput("done_one_cycle", done, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("done_count", doneCount, 1);
      checkOutput("words_delivered", hsCount, 64);
      checkOutput("queue_drained", expQ.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    start1 = 1'b0;
    out_ready1 = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      mem1[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'(i * 3);
      expMem[i] = 32'(i * 3);
    end
    mem1[5] = 32'hDEADBEEF;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_index", out_index, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_addr", mem_read_addr, 0);
    checkOutput("rst_addr1", mem_read_addr1, 5);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] full-rate stream");
    applyStimulus(0);
    $display("[TB] ready pattern 1,0,0,1");
    applyStimulus(1);
    $display("[TB] start during run");
    applyStimulus(2);
    $display("[TB] reset mid-run");
    applyStimulus(3);
    applyStimulus(0);

    $display("[TB] DEPTH=1 BASE_ADDR=5");
    begin
      int cycles;
      expQ1.push_back({32'hDEADBEEF, 16'd0, 1'b1});
      hsCount1 = 0;
      doneCount1 = 0;
      out_ready1 = 1'b1;
      checkOutput("dut1_addr_idle", mem_read_addr1, 5);
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      checkOutput("dut1_addr_run", mem_read_addr1, 5);
      cycles = 0;
      while (!done1 && cycles < 20) begin
        @(posedge clk);
        cycles++;
        #1;
      end
      checkOutput("dut1_done_latency", cycles, 2);
      @(posedge clk); #1;
      checkOutput("dut1_done_count", doneCount1, 1);
      checkOutput("dut1_words", hsCount1, 1);
      checkOutput("dut1_queue_drained", expQ1.size(), 0);
`ifdef RELU2_READER_ARGMAX_EN
      checkOutput("dut1_max_data", max_data1, 32'hDEADBEEF);
      checkOutput("dut1_max_index", max_index1, 0);
`endif
    end

`ifdef RELU2_READER_ARGMAX_EN
    $display("[TB] argmax with tie");
    for (int i = 0; i < 64; i++) begin
      mem[i] = ((i % 3) == 0) ? 32'hFFFF0000 : 32'(i);
      expMem[i] = mem[i];
    end
    mem[10] = 32'h00007FFF;
    mem[40] = 32'h00007FFF;
    expMem[10] = 32'h00007FFF;
    expMem[40] = 32'h00007FFF;
    applyStimulus(0);
    checkOutput("max_data", max_data, 32'h00007FFF);
    checkOutput("max_index", max_index, 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
